// File: rtl/alu_operand_stage.sv
// Execute-stage operand register: two-entry main+skid buffer between decode and the function unit.
// Operands are captured with writeback forwarding and kept up to date while they wait.
module alu_operand_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_fs,
  input  logic [4:0]        in_sh,
  input  logic [ADDR_W-1:0] in_aa,
  input  logic [ADDR_W-1:0] in_ba,
  input  logic [DATA_W-1:0] in_a_data,
  input  logic [DATA_W-1:0] in_b_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_mb,
  input  logic [ADDR_W-1:0] in_da,
  input  logic              in_rw,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [4:0]        SH,
  output logic [4:0]        FS,
  output logic [ADDR_W-1:0] out_da,
  output logic              out_rw,
  output logic              ILLEGAL
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        sh;
    logic [4:0]        fs;
    logic [ADDR_W-1:0] aa;
    logic [ADDR_W-1:0] ba;
    logic [ADDR_W-1:0] da;
    logic              mb;
    logic              rw;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d;
  entry_t main_fwd, skid_fwd, in_cap;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   illegal_q, illegal_d;
  logic   acc, iss;

  function automatic logic is_zero(input logic [ADDR_W-1:0] x);
    return (ZERO_REG != 0) && (x == '0);
  endfunction

  function automatic logic wb_hit(input logic en, input logic [ADDR_W-1:0] wa,
                                  input logic [ADDR_W-1:0] x);
    return en && (wa == x) && !is_zero(x);
  endfunction

  function automatic entry_t fwd_entry(input entry_t e, input logic en,
                                       input logic [ADDR_W-1:0] wa,
                                       input logic [DATA_W-1:0] wd);
    entry_t r;
    r = e;
    if (wb_hit(en, wa, e.aa)) r.a = wd;
    if (!e.mb && wb_hit(en, wa, e.ba)) r.b = wd;
    return r;
  endfunction

  function automatic logic legal_fs(input logic [4:0] f);
    case (f)
      5'b00000, 5'b00010, 5'b00101, 5'b00111, 5'b01000,
      5'b01010, 5'b01100, 5'b01110, 5'b10000, 5'b10001: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign acc = in_valid & in_ready_q;
  assign iss = out_valid_q & out_ready;

  always_comb begin
    in_cap    = '0;
    in_cap.sh = in_sh;
    in_cap.fs = in_fs;
    in_cap.aa = in_aa;
    in_cap.ba = in_ba;
    in_cap.da = in_da;
    in_cap.mb = in_mb;
    in_cap.rw = in_rw;
    if (is_zero(in_aa))                    in_cap.a = '0;
    else if (wb_hit(wb_en, wb_addr, in_aa)) in_cap.a = wb_data;
    else                                    in_cap.a = in_a_data;
    if (in_mb)                              in_cap.b = in_imm;
    else if (is_zero(in_ba))                in_cap.b = '0;
    else if (wb_hit(wb_en, wb_addr, in_ba)) in_cap.b = wb_data;
    else                                    in_cap.b = in_b_data;
  end

  // Invalid entries keep their fields; only live operands track writeback.
  assign main_fwd = (state_q != S_EMPTY) ? fwd_entry(main_q, wb_en, wb_addr, wb_data) : main_q;
  assign skid_fwd = (state_q == S_TWO)   ? fwd_entry(skid_q, wb_en, wb_addr, wb_data) : skid_q;

  always_comb begin
    state_d   = state_q;
    main_d    = main_fwd;
    skid_d    = skid_fwd;
    illegal_d = illegal_q;
    if (FLUSH) begin
      state_d = S_EMPTY;
    end else begin
      if (iss && !legal_fs(main_q.fs)) illegal_d = 1'b1;
      case (state_q)
        S_EMPTY: if (acc) begin
          main_d  = in_cap;
          state_d = S_ONE;
        end
        S_ONE: begin
          if (acc && iss) begin
            main_d = in_cap;
          end else if (acc) begin
            skid_d  = in_cap;
            state_d = S_TWO;
          end else if (iss) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: if (iss) begin
          main_d  = skid_fwd;
          state_d = S_ONE;
        end
        default: state_d = S_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != S_TWO);
    out_valid_d = (state_d != S_EMPTY);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign A         = main_q.a;
  assign B         = main_q.b;
  assign SH        = main_q.sh;
  assign FS        = main_q.fs;
  assign out_da    = main_q.da;
  assign out_rw    = main_q.rw;
  assign ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed scenarios followed by random traffic,
// checked against a queue-based model of the buffered instruction stream.
module tb_alu_operand_stage;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        FLUSH = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_fs = '0, in_sh = '0, in_aa = '0, in_ba = '0, in_da = '0;
  logic [31:0] in_a_data = '0, in_b_data = '0, in_imm = '0;
  logic        in_mb = 1'b0, in_rw = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] A, B;
  logic [4:0]  SH, FS, out_da;
  logic        out_rw, ILLEGAL;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a, b;
    logic [4:0]  sh, fs, aa, ba, da;
    logic        mb, rw;
  } ins_t;

  ins_t mq[$];
  logic m_ill = 1'b0;
  int   legal_codes[10] = '{0, 2, 5, 7, 8, 10, 12, 14, 16, 17};

  always #5 CLK = ~CLK;

  alu_operand_stage #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fs(in_fs), .in_sh(in_sh), .in_aa(in_aa), .in_ba(in_ba),
    .in_a_data(in_a_data), .in_b_data(in_b_data), .in_imm(in_imm),
    .in_mb(in_mb), .in_da(in_da), .in_rw(in_rw),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .SH(SH), .FS(FS), .out_da(out_da), .out_rw(out_rw),
    .ILLEGAL(ILLEGAL)
  );

  function automatic logic is_legal(input logic [4:0] f);
    foreach (legal_codes[i]) if (legal_codes[i] == int'(f)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] read_op(input logic [4:0] addr, input logic [31:0] rf);
    if (addr == 0) return 32'd0;
    if (wb_en && wb_addr == addr) return wb_data;
    return rf;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stream of at most two instructions, updated at each rising edge.
  initial begin
    ins_t e;
    bit   acc, iss;
    forever begin
      @(posedge CLK);
      if (RESET) begin
        mq.delete();
        m_ill = 1'b0;
      end else begin
        acc = in_valid && (mq.size() < 2);
        iss = (mq.size() > 0) && out_ready;
        if (FLUSH) begin
          mq.delete();
        end else begin
          foreach (mq[i]) begin
            if (wb_en && mq[i].aa != 0 && wb_addr == mq[i].aa) mq[i].a = wb_data;
            if (!mq[i].mb && wb_en && mq[i].ba != 0 && wb_addr == mq[i].ba) mq[i].b = wb_data;
          end
          if (iss) begin
            if (!is_legal(mq[0].fs)) m_ill = 1'b1;
            void'(mq.pop_front());
          end
          if (acc) begin
            e.a  = read_op(in_aa, in_a_data);
            e.b  = in_mb ? in_imm : read_op(in_ba, in_b_data);
            e.sh = in_sh; e.fs = in_fs; e.aa = in_aa; e.ba = in_ba;
            e.da = in_da; e.mb = in_mb; e.rw = in_rw;
            mq.push_back(e);
          end
        end
      end
    end
  end

  // Monitor: compares the presented MAIN entry with the model head every cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
        chk("ILLEGAL", {31'd0, ILLEGAL}, {31'd0, m_ill});
        if (mq.size() > 0 && out_valid) begin
          chk("A", A, mq[0].a);
          chk("B", B, mq[0].b);
          chk("SH", {27'd0, SH}, {27'd0, mq[0].sh});
          chk("FS", {27'd0, FS}, {27'd0, mq[0].fs});
          chk("out_da", {27'd0, out_da}, {27'd0, mq[0].da});
          chk("out_rw", {31'd0, out_rw}, {31'd0, mq[0].rw});
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [4:0] fs, input logic [4:0] aa, input logic [31:0] ad,
                     input logic [4:0] ba, input logic [31:0] bd, input logic [31:0] imm,
                     input logic mb, input logic [4:0] da);
    in_valid = 1'b1; in_fs = fs; in_sh = da; in_aa = aa; in_a_data = ad;
    in_ba = ba; in_b_data = bd; in_imm = imm; in_mb = mb; in_da = da; in_rw = da[0];
  endtask

  task automatic set_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_en = en; wb_addr = addr; wb_data = data;
  endtask

  initial begin
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_B", B, 32'd0);
    chk("rst_FS", {27'd0, FS}, 32'd0);
    chk("rst_SH", {27'd0, SH}, 32'd0);
    chk("rst_da_rw", {26'd0, out_da, out_rw}, 32'd0);
    chk("rst_ILLEGAL", {31'd0, ILLEGAL}, 32'd0);
    RESET = 1'b0;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Simple capture with immediate B
    put(5'b00010, 5'd3, 32'd5, 5'd6, 32'd99, 32'd7, 1'b1, 5'd1);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_A", A, 32'd5);
    chk("t1_B", B, 32'd7);
    chk("t1_FS", {27'd0, FS}, 32'd2);
    tick();

    // Back-to-back fill with a stalled consumer
    out_ready = 1'b0;
    put(5'd0, 5'd1, 32'h11, 5'd2, 32'h21, 32'd0, 1'b0, 5'd11);
    tick();
    put(5'd0, 5'd1, 32'h12, 5'd2, 32'h22, 32'd0, 1'b0, 5'd12);
    tick();
    chk("t2_full", {31'd0, in_ready}, 32'd0);
    put(5'd0, 5'd1, 32'h13, 5'd2, 32'h23, 32'd0, 1'b0, 5'd13);
    tick();
    chk("t2_held", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && !in_ready; k++) tick();
    chk("t2_release", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();

    // Writeback hitting the SKID entry as it moves into MAIN
    out_ready = 1'b0;
    put(5'd0, 5'd1, 32'h10, 5'd2, 32'h20, 32'd0, 1'b0, 5'd20);
    tick();
    put(5'd0, 5'd4, 32'h1111, 5'd2, 32'h20, 32'd0, 1'b0, 5'd21);
    tick();
    in_valid = 1'b0;
    set_wb(1'b1, 5'd4, 32'hDEAD);
    out_ready = 1'b1;
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    chk("t3_A", A, 32'hDEAD);
    chk("t3_da", {27'd0, out_da}, 32'd21);
    repeat (3) tick();

    // Register zero is never forwarded
    put(5'd0, 5'd0, 32'h55, 5'd0, 32'h66, 32'd0, 1'b0, 5'd22);
    set_wb(1'b1, 5'd0, 32'd9);
    tick();
    in_valid = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    chk("t4_A", A, 32'd0);
    chk("t4_B", B, 32'd0);
    tick();

    // Unsupported function code
    put(5'b00011, 5'd1, 32'h1, 5'd2, 32'h2, 32'd0, 1'b0, 5'd23);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t5_set", {31'd0, ILLEGAL}, 32'd1);
    repeat (3) tick();
    chk("t5_sticky", {31'd0, ILLEGAL}, 32'd1);
    RESET = 1'b1;
    #1;
    chk("t5_rst_ill", {31'd0, ILLEGAL}, 32'd0);
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    tick();
    RESET = 1'b0;
    tick();

    // FLUSH while full, with a competing input
    out_ready = 1'b0;
    put(5'd0, 5'd1, 32'h31, 5'd2, 32'h41, 32'd0, 1'b0, 5'd24);
    tick();
    put(5'd0, 5'd1, 32'h32, 5'd2, 32'h42, 32'd0, 1'b0, 5'd25);
    tick();
    put(5'd0, 5'd1, 32'h33, 5'd2, 32'h43, 32'd0, 1'b0, 5'd31);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    in_valid = 1'b0;
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (3) tick();

    // Random traffic
    repeat (800) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_fs     = ($urandom_range(0, 9) != 0) ? 5'(legal_codes[$urandom_range(0, 9)]) : 5'($urandom);
      in_sh     = 5'($urandom);
      in_aa     = 5'($urandom_range(0, 7));
      in_ba     = 5'($urandom_range(0, 7));
      in_a_data = $urandom;
      in_b_data = $urandom;
      in_imm    = $urandom;
      in_mb     = 1'($urandom);
      in_da     = 5'($urandom);
      in_rw     = 1'($urandom);
      set_wb(($urandom_range(0, 1) != 0), 5'($urandom_range(0, 7)), $urandom);
      FLUSH     = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0;
    FLUSH = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    out_ready = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
